// File: rtl/wave_hold_if.sv
// Handshake and read bundle for the waveform hold buffer.
// Ports: writer strobe/sample, live switch, read request/address, read result, status flags.
interface wave_hold_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              live_sw;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frozen;
  logic              fill_full;

  modport master (
    output sample_valid,
    output sample_in,
    output live_sw,
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  rd_valid,
    input  frozen,
    input  fill_full
  );

  modport slave (
    input  sample_valid,
    input  sample_in,
    input  live_sw,
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_valid,
    output frozen,
    output fill_full
  );
endinterface

// File: rtl/wave_hold_buffer.sv
// Circular sample store with live/hold capture and oldest-first logical reads.
// Ports: wave_clock, rst_n (sync, active low), bus (wave_hold_if.slave).
module wave_hold_buffer #(
  parameter int DATA_W       = 12,
  parameter int ADDR_W       = 8,
  parameter int POST_SAMPLES = 128
) (
  input logic        wave_clock,
  input logic        rst_n,
  wave_hold_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] POST_N = (ADDR_W+1)'(POST_SAMPLES);

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    DRAIN  = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W:0]   post_cnt;
  logic [ADDR_W:0]   post_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   fill_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              full;
  logic              rd_hole;
  logic [ADDR_W-1:0] rd_phys;

  always_ff @(posedge wave_clock) begin
    if (!rst_n) begin
      state    <= LIVE;
      post_cnt <= '0;
    end else begin
      state    <= state_nx;
      post_cnt <= post_nx;
    end
  end

  always_comb begin
    state_nx = state;
    post_nx  = post_cnt;
    unique case (state)
      LIVE: begin
        if (!bus.live_sw) begin
          if (POST_N == '0) begin
            state_nx = FROZEN;
          end else begin
            state_nx = DRAIN;
            post_nx  = POST_N;
          end
        end
      end
      DRAIN: begin
        if (bus.live_sw) begin
          state_nx = LIVE;
          post_nx  = '0;
        end else if (bus.sample_valid) begin
          // the write that empties the counter is stored, then we freeze
          post_nx = post_cnt - 1'b1;
          if (post_cnt == 1) state_nx = FROZEN;
        end
      end
      FROZEN: begin
        if (bus.live_sw) state_nx = LIVE;
      end
      default: begin
        state_nx = LIVE;
        post_nx  = '0;
      end
    endcase
  end

  always_comb begin
    bus.frozen = (state == FROZEN);
  end

  assign full          = (fill_cnt == FULL_CNT);
  assign bus.fill_full = full;
  assign wr_en = rst_n && bus.sample_valid && (state != FROZEN);

  // once wrapped, the slot at wr_ptr holds the oldest sample
  assign rd_phys = full ? (wr_ptr + bus.rd_addr) : bus.rd_addr;
  assign rd_hole = !full && ({1'b0, bus.rd_addr} >= fill_cnt);

  // memory has no reset; read-first falls out of non-blocking update
  always_ff @(posedge wave_clock) begin
    if (wr_en) mem[wr_ptr] <= bus.sample_in;
  end

  always_ff @(posedge wave_clock) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!full) fill_cnt <= fill_cnt + 1'b1;
      end
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data <= rd_hole ? '0 : mem[rd_phys];
      end
    end
  end
endmodule

// File: tb/tb_wave_hold_buffer.sv
// Directed self-checking bench for wave_hold_buffer (ADDR_W=4, POST_SAMPLES=8).
// Expected read data is queued at request time and compared one cycle later.
module tb_wave_hold_buffer;
  localparam int DW = 12;
  localparam int AW = 4;

  logic wave_clock = 1'b0;
  logic rst_n      = 1'b0;

  wave_hold_if #(.DATA_W(DW), .ADDR_W(AW)) wif ();

  wave_hold_buffer #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .POST_SAMPLES(8)
  ) dut (
    .wave_clock(wave_clock),
    .rst_n(rst_n),
    .bus(wif.slave)
  );

  always #5 wave_clock = ~wave_clock;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_data = '0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic prev_re;
    logic prev_rst;
    logic [DW-1:0] e;
    prev_re  = wif.rd_en;
    prev_rst = rst_n;
    @(posedge wave_clock);
    #1;
    if (!prev_rst) begin
      last_data = '0;
      check("rst_rd_valid", 32'(wif.rd_valid), 32'd0);
      check("rst_rd_data", 32'(wif.rd_data), 32'd0);
    end else begin
      check("rd_valid", 32'(wif.rd_valid), 32'(prev_re));
      if (prev_re) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 32'(wif.rd_data), 32'(e));
          last_data = e;
        end
      end else begin
        check("rd_hold", 32'(wif.rd_data), 32'(last_data));
      end
    end
  endtask

  task automatic drive(logic sv, logic [DW-1:0] din, logic re,
                       logic [AW-1:0] ra, logic [DW-1:0] exp);
    wif.sample_valid = sv;
    wif.sample_in    = din;
    wif.rd_en        = re;
    wif.rd_addr      = ra;
    if (re && rst_n) exp_q.push_back(exp);
    cycle();
    wif.sample_valid = 1'b0;
    wif.rd_en        = 1'b0;
  endtask

  task automatic wr(logic [DW-1:0] v);
    drive(1'b1, v, 1'b0, '0, '0);
  endtask

  task automatic rd(logic [AW-1:0] a, logic [DW-1:0] e);
    drive(1'b0, '0, 1'b1, a, e);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wif.sample_valid = 1'b0;
    wif.sample_in    = '0;
    wif.live_sw      = 1'b1;
    wif.rd_en        = 1'b0;
    wif.rd_addr      = '0;

    // reset state
    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
    check("rst_frozen", 32'(wif.frozen), 32'd0);
    check("rst_fill_full", 32'(wif.fill_full), 32'd0);

    // partial fill, unwritten slots read as zero
    for (int v = 1; v <= 5; v++) wr(DW'(v));
    for (int a = 0; a <= 6; a++) rd(AW'(a), (a < 5) ? DW'(a + 1) : DW'(0));
    idle();
    check("partial_fill_full", 32'(wif.fill_full), 32'd0);

    // wrap: 20 writes after reset, oldest is sample 5
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    for (int v = 1; v <= 20; v++) begin
      wr(DW'(v));
      if (v == 15) check("fill_full_15", 32'(wif.fill_full), 32'd0);
      if (v == 16) check("fill_full_16", 32'(wif.fill_full), 32'd1);
    end
    check("wrap_fill_full", 32'(wif.fill_full), 32'd1);
    for (int a = 0; a < 16; a++) rd(AW'(a), DW'(a + 5));
    idle();

    // hold request: freeze lands on the 8th post sample (28)
    wif.live_sw = 1'b0;
    idle();
    check("drain_entry_frozen", 32'(wif.frozen), 32'd0);
    for (int v = 21; v <= 40; v++) begin
      wr(DW'(v));
      check("drain_frozen", 32'(wif.frozen), (v >= 28) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < 16; a++) rd(AW'(a), DW'(a + 13));
    idle();

    // release: writing resumes at the held pointer
    wif.live_sw = 1'b1;
    idle();
    check("release_frozen", 32'(wif.frozen), 32'd0);
    wr(DW'(41));
    rd(AW'(15), DW'(41));
    rd(AW'(0), DW'(14));
    idle();

    // abort drain after 3 samples, then a full 8 are needed
    wif.live_sw = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      wr(DW'(50 + i));
      check("abort_pre_frozen", 32'(wif.frozen), 32'd0);
    end
    wif.live_sw = 1'b1;
    idle();
    check("abort_frozen_a", 32'(wif.frozen), 32'd0);
    idle();
    check("abort_frozen_b", 32'(wif.frozen), 32'd0);
    wif.live_sw = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) begin
      wr(DW'(60 + i));
      check("redrain_frozen", 32'(wif.frozen), (i == 7) ? 32'd1 : 32'd0);
    end
    rd(AW'(0), DW'(25));

    // reset while frozen with a read pending
    wif.live_sw = 1'b1;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b1, '0, '0);
    rst_n = 1'b1;
    check("frz_rst_frozen", 32'(wif.frozen), 32'd0);
    check("frz_rst_fill_full", 32'(wif.fill_full), 32'd0);
    rd(AW'(0), DW'(0));
    idle();

    // same-slot write and read: old value first, new value later
    for (int i = 0; i < 16; i++) wr(DW'(100 + i));
    drive(1'b1, DW'(200), 1'b1, AW'(0), DW'(100));
    rd(AW'(15), DW'(200));
    rd(AW'(0), DW'(101));
    idle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wave_hold_buffer.md
Name: wave_hold_buffer

Overview:
- Circular sample store between the mic sample path (writer) and the waveform display scanner (reader).
- live_sw=1: buffer tracks incoming samples continuously. live_sw=0: buffer captures POST_SAMPLES further samples, then freezes so the display can re-read a stable waveform.
- Read port addresses are logical: address 0 is always the oldest stored sample.

Parameters:
DATA_W, 12, sample width in bits
ADDR_W, 8, address width; DEPTH = 2^ADDR_W entries
POST_SAMPLES, 128, samples written after freeze request before halting; legal range 0..DEPTH

Ports:
wave_clock  in  1  system clock; all state changes on its rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising wave_clock
sample_valid  in  1  single-cycle strobe; sample_in is valid
sample_in  in  DATA_W  mic sample
live_sw  in  1  1 = live update, 0 = request hold; already debounced and synchronous
rd_en  in  1  read request
rd_addr  in  ADDR_W  logical read address, 0 = oldest sample
rd_data  out  DATA_W  read result
rd_valid  out  1  rd_data is valid this cycle
frozen  out  1  buffer contents stable; no writes occurring
fill_full  out  1  DEPTH samples have been written since reset

Behaviour:
- Reset (rst_n=0 at edge):
  - state=LIVE, wr_ptr=0, fill count=0, post counter=0.
  - rd_data=0, rd_valid=0, frozen=0, fill_full=0.
  - Memory contents are not cleared. Reset overrides every other input, including mid-DRAIN or in FROZEN.
- States and transitions:
  - LIVE: live_sw=0 -> DRAIN with post counter=POST_SAMPLES. If POST_SAMPLES=0, go directly to FROZEN instead.
  - DRAIN: live_sw=1 -> LIVE (abort; counter cleared). A write that drops the counter to 0 -> FROZEN at the same edge. That write is stored.
  - FROZEN: live_sw=1 -> LIVE. Writing resumes at the current wr_ptr; existing data is kept.
- Write rules:
  - In LIVE and DRAIN, sample_valid=1 writes sample_in to mem[wr_ptr] and increments wr_ptr modulo DEPTH (DEPTH-1 wraps to 0).
  - Each write increments the fill count, which saturates at DEPTH. fill_full=1 once the count equals DEPTH.
  - In FROZEN, sample_valid is ignored; wr_ptr and fill count hold.
- Simultaneous live_sw=0 and sample_valid=1 in LIVE: the sample is written. It does not count toward POST_SAMPLES; only writes made while in DRAIN decrement the counter.
- Read address mapping:
  - Fill count < DEPTH: physical address = rd_addr.
  - Otherwise: physical address = (wr_ptr + rd_addr) mod DEPTH.
  - Mapping uses the wr_ptr value before any same-cycle write.
- Read timing:
  - rd_en=1 at edge t gives rd_valid=1 and rd_data at edge t+1. Latency is 1 cycle; one read per cycle, fully pipelined.
  - rd_en=0 gives rd_valid=0; rd_data holds its last value.
- Unwritten locations: rd_addr >= fill count (before fill_full) returns rd_data=0 with rd_valid=1.
- Read/write collision on the same physical address in one cycle: read returns the old contents (read-first).
- frozen=1 exactly when state=FROZEN, registered. It asserts on the edge that enters FROZEN and deasserts on the edge leaving it.

Test Plan:
- Bench uses ADDR_W=4, POST_SAMPLES=8.
- Reset, then write samples 1..5 and read addresses 0..6 -> rd_data 1,2,3,4,5,0,0 one cycle after each rd_en; fill_full=0.
- Write samples 1..20 with live_sw=1 -> fill_full=1; reads of addresses 0..15 return 5..20 (wrap handled).
- After 20 writes, drop live_sw, then write 21..40 -> frozen=1 on the edge of sample 28. Addresses 0..15 return 13..28; samples 29..40 are ignored.
- Freeze state from the previous case, raise live_sw and write 41 -> frozen=0 next edge; address 15 returns 41, address 0 returns 14.
- In DRAIN after 3 post-samples, raise live_sw -> state LIVE, frozen never asserts. Drop live_sw again -> a full 8 further samples are required before frozen=1.
- Assert rst_n=0 while frozen with data present -> next edge frozen=0, rd_valid=0, fill_full=0; read of address 0 returns 0.
- Write and read the same physical slot in one cycle -> old value returned; the new value is returned on the next read.
